// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM state encoding and the misalignment rule.
package dmem_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   // Store funct3 codes share the load encodings, so one rule covers both.
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if ((funct3 == F3_LH) || (funct3 == F3_LHU)) mis = off[0];
      else if (funct3 == F3_LW)                    mis = (off != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: store byte-enables / replicated write data, and
// load result extraction with sign or zero extension.
module lsu_align
   import dmem_lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic            st_we,
   input  logic [2:0]      st_funct3,
   input  logic [1:0]      st_off,
   input  logic [XLEN-1:0] st_wdata_raw,
   output logic [BE_W-1:0] st_be,
   output logic [XLEN-1:0] st_wdata,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] sh;

   always_comb begin
      st_be    = '1;
      st_wdata = st_wdata_raw;
      if (st_we) begin
         case (st_funct3)
            F3_SB: begin
               st_be    = BE_W'(1) << st_off;
               st_wdata = {BE_W{st_wdata_raw[7:0]}};
            end
            F3_SH: begin
               st_be    = BE_W'(3) << st_off;
               st_wdata = {(BE_W/2){st_wdata_raw[15:0]}};
            end
            F3_SW:   st_be = '1;
            default: st_be = '0;
         endcase
      end
   end

   assign sh = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data = '0;
      case (ld_funct3)
         F3_LB:   ld_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
         F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, sh[7:0]};
         F3_LH:   ld_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
         F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, sh[15:0]};
         F3_LW:   ld_data = ld_rdata;
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Memory-stage load/store unit: runs one req/gnt/rvalid data-bus transaction
// per memory instruction and holds the stage until writeback accepts it.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic            clk_i,
   input  logic            rst,
   input  logic            execute_vaild_i,
   input  logic            write_back_allow_in_i,
   input  logic            ED_mem_rd_i,
   input  logic            ED_mem_wr_i,
   input  logic [2:0]      ED_funct3_i,
   input  logic [XLEN-1:0] ED_valE_i,
   input  logic [XLEN-1:0] ED_wdata_i,
   output logic            memory_ready_o,
   output logic [XLEN-1:0] M_valM_o,
   output logic            M_misalign_o,
   output logic            dbus_req_o,
   output logic            dbus_we_o,
   output logic [XLEN-1:0] dbus_addr_o,
   output logic [XLEN-1:0] dbus_wdata_o,
   output logic [BE_W-1:0] dbus_be_o,
   input  logic            dbus_gnt_i,
   input  logic            dbus_rvalid_i,
   input  logic [XLEN-1:0] dbus_rdata_i
);

   lsu_state_e state_q, state_d;

   logic [XLEN-1:0] addr_q, wdata_q, valm_q;
   logic [2:0]      f3_q;
   logic            we_q;
   logic [BE_W-1:0] be_q;

   logic            mem_op, st_op, misalign;
   logic [BE_W-1:0] st_be;
   logic [XLEN-1:0] st_wdata, ld_data;
   logic            latch_en, cap_en, clr_en;
   logic            ready_c, mis_c, req_c;

   // Both rd and wr asserted is illegal and falls back to a load.
   assign mem_op   = ED_mem_rd_i | ED_mem_wr_i;
   assign st_op    = ED_mem_wr_i & ~ED_mem_rd_i;
   assign misalign = lsu_misaligned(ED_funct3_i, ED_valE_i[1:0]);

   lsu_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align (
      .st_we        (st_op),
      .st_funct3    (ED_funct3_i),
      .st_off       (ED_valE_i[1:0]),
      .st_wdata_raw (ED_wdata_i),
      .st_be        (st_be),
      .st_wdata     (st_wdata),
      .ld_funct3    (f3_q),
      .ld_off       (addr_q[1:0]),
      .ld_rdata     (dbus_rdata_i),
      .ld_data      (ld_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst) state_q <= LSU_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      cap_en   = 1'b0;
      clr_en   = 1'b0;
      ready_c  = 1'b0;
      mis_c    = 1'b0;
      req_c    = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            ready_c = execute_vaild_i & (~mem_op | misalign);
            mis_c   = execute_vaild_i & mem_op & misalign;
            if (execute_vaild_i & mem_op & ~misalign) begin
               latch_en = 1'b1;
               state_d  = LSU_REQ;
            end
         end
         LSU_REQ: begin
            req_c = 1'b1;
            if (dbus_gnt_i) begin
               if (dbus_rvalid_i) begin
                  cap_en  = 1'b1;
                  state_d = LSU_DONE;
               end else begin
                  state_d = LSU_WAIT;
               end
            end
         end
         LSU_WAIT: begin
            if (dbus_rvalid_i) begin
               cap_en  = 1'b1;
               state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            ready_c = 1'b1;
            if (write_back_allow_in_i) begin
               clr_en  = 1'b1;
               state_d = LSU_IDLE;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
      if (rst) begin
         ready_c = 1'b0;
         mis_c   = 1'b0;
         req_c   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         valm_q  <= '0;
      end else begin
         if (latch_en) begin
            addr_q  <= ED_valE_i;
            wdata_q <= st_wdata;
            f3_q    <= ED_funct3_i;
            we_q    <= st_op;
            be_q    <= st_be;
         end
         if (cap_en)      valm_q <= we_q ? '0 : ld_data;
         else if (clr_en) valm_q <= '0;
      end
   end

   assign memory_ready_o = ready_c;
   assign M_misalign_o   = mis_c;
   assign M_valM_o       = (state_q == LSU_DONE && !rst) ? valm_q : '0;
   assign dbus_req_o     = req_c;
   assign dbus_we_o      = we_q;
   assign dbus_addr_o    = {addr_q[XLEN-1:2], 2'b00};
   assign dbus_wdata_o   = wdata_q;
   assign dbus_be_o      = be_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed plan items plus randomized
// transactions against a behavioural load/store model.
module tb_dmem_lsu;

   logic        clk_i = 1'b0;
   logic        rst;
   logic        execute_vaild_i, write_back_allow_in_i;
   logic        ED_mem_rd_i, ED_mem_wr_i;
   logic [2:0]  ED_funct3_i;
   logic [31:0] ED_valE_i, ED_wdata_i;
   logic        memory_ready_o, M_misalign_o;
   logic [31:0] M_valM_o;
   logic        dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic        dbus_gnt_i, dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   dmem_lsu dut (
      .clk_i                 (clk_i),
      .rst                   (rst),
      .execute_vaild_i       (execute_vaild_i),
      .write_back_allow_in_i (write_back_allow_in_i),
      .ED_mem_rd_i           (ED_mem_rd_i),
      .ED_mem_wr_i           (ED_mem_wr_i),
      .ED_funct3_i           (ED_funct3_i),
      .ED_valE_i             (ED_valE_i),
      .ED_wdata_i            (ED_wdata_i),
      .memory_ready_o        (memory_ready_o),
      .M_valM_o              (M_valM_o),
      .M_misalign_o          (M_misalign_o),
      .dbus_req_o            (dbus_req_o),
      .dbus_we_o             (dbus_we_o),
      .dbus_addr_o           (dbus_addr_o),
      .dbus_wdata_o          (dbus_wdata_o),
      .dbus_be_o             (dbus_be_o),
      .dbus_gnt_i            (dbus_gnt_i),
      .dbus_rvalid_i         (dbus_rvalid_i),
      .dbus_rdata_i          (dbus_rdata_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: byte/half picked arithmetically from the word.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
      longint w, b, h;
      w = longint'(rdata);
      b = (w / (longint'(1) << (8 * off))) % 256;
      h = (w / (longint'(1) << (8 * off))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
         3'd4:    return 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         3'd5:    return 32'(h);
         3'd2:    return rdata;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
      if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
      if (f3 == 3'd2)               return (addr % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
      int off;
      off = int'(addr % 4);
      case (f3)
         3'd0:    return 4'(1 << off);
         3'd1:    return 4'(3 << off);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         3'd0:    return (wd % 256) * 32'h0101_0101;
         3'd1:    return (wd % 65536) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   // One instruction through the stage. gd: REQ cycles before gnt,
   // rd_dly: cycles from gnt to rvalid, ad: DONE cycles before allow_in.
   task automatic do_mem(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int gd, input int rd_dly,
                         input int ad);
      logic        memop, is_st, mis;
      logic [31:0] exp_val, exp_addr;
      logic [3:0]  exp_be;
      memop    = rd | wr;
      is_st    = wr & ~rd;
      mis      = memop & ref_mis(f3, addr);
      exp_val  = is_st ? 32'd0 : ref_load(f3, 2'(addr % 4), rdata);
      exp_addr = addr - (addr % 4);
      exp_be   = is_st ? ref_be(f3, addr) : 4'hF;

      @(negedge clk_i);
      ED_mem_rd_i = rd; ED_mem_wr_i = wr; ED_funct3_i = f3;
      ED_valE_i = addr; ED_wdata_i = wd;
      execute_vaild_i = 1'b1; write_back_allow_in_i = 1'b0;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
      #1;
      if (!memop || mis) begin
         check("imm_ready", 32'(memory_ready_o), 32'd1);
         check("imm_misalign", 32'(M_misalign_o), 32'(mis));
         check("imm_req", 32'(dbus_req_o), 32'd0);
         check("imm_valM", M_valM_o, 32'd0);
         @(negedge clk_i);
         execute_vaild_i = 1'b0;
         #1;
         check("imm_req_after", 32'(dbus_req_o), 32'd0);
         check("imm_ready_after", 32'(memory_ready_o), 32'd0);
         return;
      end
      check("start_ready", 32'(memory_ready_o), 32'd0);
      check("start_req", 32'(dbus_req_o), 32'd0);

      for (int k = 0; k <= gd; k++) begin
         @(negedge clk_i);
         dbus_gnt_i    = (k == gd);
         dbus_rvalid_i = (k == gd) ? (rd_dly == 0) : 1'($urandom_range(0, 1));
         dbus_rdata_i  = (k == gd && rd_dly == 0) ? rdata : $urandom;
         #1;
         check("req_req", 32'(dbus_req_o), 32'd1);
         check("req_addr", dbus_addr_o, exp_addr);
         check("req_we", 32'(dbus_we_o), 32'(is_st));
         check("req_be", 32'(dbus_be_o), 32'(exp_be));
         if (is_st) check("req_wdata", dbus_wdata_o, ref_wdata(f3, wd));
         check("req_ready", 32'(memory_ready_o), 32'd0);
      end

      for (int j = 1; j <= rd_dly; j++) begin
         @(negedge clk_i);
         dbus_gnt_i    = 1'b0;
         dbus_rvalid_i = (j == rd_dly);
         dbus_rdata_i  = (j == rd_dly) ? rdata : $urandom;
         #1;
         check("wait_req", 32'(dbus_req_o), 32'd0);
         check("wait_ready", 32'(memory_ready_o), 32'd0);
         check("wait_valM", M_valM_o, 32'd0);
      end

      for (int a = 0; a <= ad; a++) begin
         @(negedge clk_i);
         dbus_gnt_i = 1'b0;
         dbus_rvalid_i = 1'($urandom_range(0, 1));
         dbus_rdata_i = $urandom;
         write_back_allow_in_i = (a == ad);
         #1;
         check("done_ready", 32'(memory_ready_o), 32'd1);
         check("done_valM", M_valM_o, exp_val);
         check("done_req", 32'(dbus_req_o), 32'd0);
      end

      @(negedge clk_i);
      execute_vaild_i = 1'b0; write_back_allow_in_i = 1'b0; dbus_rvalid_i = 1'b0;
      #1;
      check("idle_ready", 32'(memory_ready_o), 32'd0);
      check("idle_valM", M_valM_o, 32'd0);
      check("idle_req", 32'(dbus_req_o), 32'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      int          kind;

      rst = 1'b1;
      execute_vaild_i = 1'b1; write_back_allow_in_i = 1'b1;
      ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0; ED_funct3_i = 3'd0;
      ED_valE_i = 32'h0; ED_wdata_i = 32'h0;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;

      // Reset state: ready forced low even with a valid non-memory op.
      repeat (2) begin
         @(negedge clk_i);
         #1;
         check("rst_ready", 32'(memory_ready_o), 32'd0);
         check("rst_req", 32'(dbus_req_o), 32'd0);
         check("rst_valM", M_valM_o, 32'd0);
         check("rst_misalign", 32'(M_misalign_o), 32'd0);
      end
      @(negedge clk_i);
      rst = 1'b0; execute_vaild_i = 1'b0; write_back_allow_in_i = 1'b0;

      // Plan 1..5
      do_mem(1'b0, 1'b0, 3'd0, 32'h1234_5677, 32'h0, 32'h0, 0, 1, 0);
      do_mem(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1, 0);
      do_mem(1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1, 0);
      do_mem(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 1, 0);
      do_mem(1'b1, 1'b0, 3'd2, 32'h0000_3002, 32'h0, 32'h0, 0, 1, 0);
      do_mem(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 1, 4);
      do_mem(1'b0, 1'b1, 3'd0, 32'h0000_4001, 32'h0000_00A5, 32'h0, 0, 0, 0);
      do_mem(1'b1, 1'b0, 3'd5, 32'h0000_4002, 32'h0, 32'h9876_5432, 1, 0, 1);

      // Plan 6: reset while WAITing; the late rvalid must be ignored.
      @(negedge clk_i);
      ED_mem_rd_i = 1'b1; ED_mem_wr_i = 1'b0; ED_funct3_i = 3'd2;
      ED_valE_i = 32'h0000_5000; execute_vaild_i = 1'b1;
      @(negedge clk_i);
      dbus_gnt_i = 1'b1;
      #1;
      check("r6_req", 32'(dbus_req_o), 32'd1);
      @(negedge clk_i);
      dbus_gnt_i = 1'b0; rst = 1'b1;
      #1;
      check("r6_rst_ready", 32'(memory_ready_o), 32'd0);
      check("r6_rst_req", 32'(dbus_req_o), 32'd0);
      @(negedge clk_i);
      rst = 1'b0; execute_vaild_i = 1'b0;
      dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
      #1;
      check("r6_late_ready", 32'(memory_ready_o), 32'd0);
      check("r6_late_req", 32'(dbus_req_o), 32'd0);
      @(negedge clk_i);
      dbus_rvalid_i = 1'b0;
      #1;
      check("r6_after_ready", 32'(memory_ready_o), 32'd0);
      check("r6_after_valM", M_valM_o, 32'd0);
      do_mem(1'b1, 1'b0, 3'd1, 32'h0000_5006, 32'h0, 32'h8001_7FFF, 0, 1, 0);

      // Randomized mix of all instruction kinds and bus timings.
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
         if (kind >= 6) begin
            f3 = 3'($urandom_range(0, 2));
            do_mem(1'b0, 1'b1, f3, addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         end else begin
            case ($urandom_range(0, 7))
               0: f3 = 3'd0;  1: f3 = 3'd1;  2: f3 = 3'd2;  3: f3 = 3'd4;
               4: f3 = 3'd5;  5: f3 = 3'd3;  6: f3 = 3'd6;  default: f3 = 3'd2;
            endcase
            do_mem(kind != 0, kind == 1, f3, addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
